dm_responder: RTL and testbench

//   Memory-side responder for the CPU data port: serves m_data_addr/m_data_wdata/m_data_byteen

---
 rtl/dm_responder.sv | 81 ++++++++
 tb/tb_dm_responder.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// dm_responder: word RAM serving the CPU data port with a valid/ready trace FIFO of accepted stores
module dm_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [31:0]                   m_data_addr,
  input  logic [31:0]                   m_data_wdata,
  input  logic [3:0]                    m_data_byteen,
  input  logic [31:0]                   m_inst_addr,
  output logic [31:0]                   m_data_rdata,
  output logic                          trace_valid,
  input  logic                          trace_ready,
  output logic [31:0]                   trace_pc,
  output logic [31:0]                   trace_addr,
  output logic [31:0]                   trace_data,
  output logic [3:0]                    trace_byteen,
  output logic [$clog2(FIFO_DEPTH):0]   trace_count,
  output logic                          trace_ovf,
  output logic                          addr_err
);
  localparam int WORDS = 2 ** ADDR_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  logic [31:0] ram [WORDS];
  logic [31:0] f_pc [FIFO_DEPTH];
  logic [31:0] f_addr [FIFO_DEPTH];
  logic [31:0] f_data [FIFO_DEPTH];
  logic [3:0] f_be [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [ADDR_WIDTH-1:0] idx;
  logic in_range, store, push_req, push, pop, full;
  logic [31:0] old_word, merged, aligned;
  assign idx = m_data_addr[ADDR_WIDTH+1:2];
  assign in_range = m_data_addr[31:ADDR_WIDTH+2] == '0;
  assign aligned = m_data_addr & 32'hFFFF_FFFC;
  assign old_word = ram[idx];
  assign store = |m_data_byteen;
  assign push_req = store && in_range;
  assign full = count == CW'(FIFO_DEPTH);
  assign pop = trace_valid && trace_ready;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign push = push_req && (!full || pop);
  assign m_data_rdata = in_range ? old_word : 32'h0;
  assign trace_valid = count != '0;
  assign trace_count = count;
  assign trace_pc = trace_valid ? f_pc[rd_ptr] : 32'h0;
  assign trace_addr = trace_valid ? f_addr[rd_ptr] : 32'h0;
  assign trace_data = trace_valid ? f_data[rd_ptr] : 32'h0;
  assign trace_byteen = trace_valid ? f_be[rd_ptr] : 4'h0;
  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++)
      merged[8*i +: 8] = m_data_byteen[i] ? m_data_wdata[8*i +: 8] : old_word[8*i +: 8];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) ram[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      trace_ovf <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      if (push_req) ram[idx] <= merged;
      if (store && !in_range) addr_err <= 1'b1;
      if (push) begin
        f_pc[wr_ptr] <= m_inst_addr;
        f_addr[wr_ptr] <= aligned;
        f_data[wr_ptr] <= merged;
        f_be[wr_ptr] <= m_data_byteen;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (push_req && !push) trace_ovf <= 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed stores with a scoreboard of expected trace entries checked by a monitor
module tb_dm_responder;
  logic clk = 0, reset = 1;
  logic [31:0] m_data_addr = 0, m_data_wdata = 0, m_inst_addr = 0;
  logic [3:0] m_data_byteen = 0;
  logic trace_ready = 0;
  logic [31:0] m_data_rdata, trace_pc, trace_addr, trace_data;
  logic [3:0] trace_byteen;
  logic [3:0] trace_count;
  logic trace_valid, trace_ovf, addr_err;
  int checks = 0, errors = 0;
  typedef struct {logic [31:0] pc, addr, data; logic [3:0] be;} entry_t;
  entry_t sb[$];

  dm_responder dut (
    .clk(clk), .reset(reset), .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
    .m_data_byteen(m_data_byteen), .m_inst_addr(m_inst_addr), .m_data_rdata(m_data_rdata),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_pc(trace_pc),
    .trace_addr(trace_addr), .trace_data(trace_data), .trace_byteen(trace_byteen),
    .trace_count(trace_count), .trace_ovf(trace_ovf), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // inputs change 1 time unit after the rising edge; everything is sampled on the falling edge
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                      input logic [31:0] pc, input logic rdy);
    @(posedge clk); #1;
    m_data_addr = a; m_data_wdata = d; m_data_byteen = be; m_inst_addr = pc; trace_ready = rdy;
    @(negedge clk);
  endtask

  task automatic expect_push(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] be);
    entry_t e;
    e.pc = pc; e.addr = a; e.data = d; e.be = be;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset && trace_valid && trace_ready) begin
      if (sb.size() == 0) chk("unexpected_pop", {28'h0, trace_count}, 32'h0);
      else begin
        chk("trace_pc", trace_pc, sb[0].pc);
        chk("trace_addr", trace_addr, sb[0].addr);
        chk("trace_data", trace_data, sb[0].data);
        chk("trace_byteen", {28'h0, trace_byteen}, {28'h0, sb[0].be});
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    step(0, 0, 0, 0, 0);
    reset = 0;
    chk("rst_count", {28'h0, trace_count}, 0);
    chk("rst_valid", {31'h0, trace_valid}, 0);
    chk("rst_ovf", {31'h0, trace_ovf}, 0);
    chk("rst_err", {31'h0, addr_err}, 0);
    chk("rst_tdata", trace_data, 0);
    chk("rst_rdata", m_data_rdata, 0);
    // full-word store then byte store to the same word
    step(32'h10, 32'h1122_3344, 4'hF, 32'h400, 0);
    expect_push(32'h400, 32'h10, 32'h1122_3344, 4'hF);
    chk("rdata_before_sw", m_data_rdata, 0);
    step(32'h13, 32'hAA00_0000, 4'h8, 32'h404, 0);
    expect_push(32'h404, 32'h10, 32'hAA22_3344, 4'h8);
    chk("rdata_sameedge_sb", m_data_rdata, 32'h1122_3344);
    chk("count1", {28'h0, trace_count}, 1);
    step(32'h10, 0, 0, 0, 0);
    chk("rdata_after_sb", m_data_rdata, 32'hAA22_3344);
    chk("count2", {28'h0, trace_count}, 2);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("drained_count", {28'h0, trace_count}, 0);
    chk("drained_valid", {31'h0, trace_valid}, 0);
    // fill the FIFO, then overflow it
    for (int k = 0; k < 8; k++) begin
      step(32'h100 + 4 * k, 32'hC0DE_0000 + k, 4'hF, 32'h1000 + 4 * k, 0);
      expect_push(32'h1000 + 4 * k, 32'h100 + 4 * k, 32'hC0DE_0000 + k, 4'hF);
    end
    step(32'h200, 32'h0000_DEAD, 4'hF, 32'h2000, 0);
    chk("full_count", {28'h0, trace_count}, 8);
    chk("ovf_before", {31'h0, trace_ovf}, 0);
    step(32'h200, 0, 0, 0, 0);
    chk("ovf_count", {28'h0, trace_count}, 8);
    chk("ovf_set", {31'h0, trace_ovf}, 1);
    chk("ovf_head_pc", trace_pc, 32'h1000);
    chk("dropped_still_in_ram", m_data_rdata, 32'h0000_DEAD);
    // push and pop together while full
    step(32'h300, 32'h55AA_55AA, 4'hF, 32'h3000, 1);
    expect_push(32'h3000, 32'h300, 32'h55AA_55AA, 4'hF);
    step(0, 0, 0, 0, 0);
    chk("pushpop_count", {28'h0, trace_count}, 8);
    chk("pushpop_ovf", {31'h0, trace_ovf}, 1);
    chk("pushpop_head", trace_pc, 32'h1004);
    // out-of-range store aliases word 0 but must not touch it
    step(32'h0001_0000, 32'h1234_5678, 4'hF, 32'h5000, 0);
    chk("oor_rdata", m_data_rdata, 0);
    chk("oor_err_pre", {31'h0, addr_err}, 0);
    step(32'h0, 0, 0, 0, 0);
    chk("oor_word0", m_data_rdata, 0);
    chk("oor_err", {31'h0, addr_err}, 1);
    chk("oor_count", {28'h0, trace_count}, 8);
    for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("empty_after_drain", {28'h0, trace_count}, 0);
    chk("sb_empty", sb.size(), 0);
    // reset in the middle of a store burst
    for (int k = 0; k < 5; k++) begin
      step(32'h40 + 4 * k, 32'hBEEF_0000 + k, 4'hF, 32'h6000 + 4 * k, 0);
      expect_push(32'h6000 + 4 * k, 32'h40 + 4 * k, 32'hBEEF_0000 + k, 4'hF);
    end
    @(posedge clk); #1;
    m_data_addr = 32'h60; m_data_wdata = 32'hFFFF_FFFF; m_data_byteen = 4'hF; reset = 1;
    sb.delete();
    @(negedge clk);
    chk("pre_reset_count", {28'h0, trace_count}, 5);
    step(32'h40, 0, 0, 0, 0);
    reset = 0;
    chk("post_reset_count", {28'h0, trace_count}, 0);
    chk("post_reset_valid", {31'h0, trace_valid}, 0);
    chk("post_reset_ovf", {31'h0, trace_ovf}, 0);
    chk("post_reset_err", {31'h0, addr_err}, 0);
    chk("post_reset_rdata", m_data_rdata, 0);
    step(32'h60, 0, 0, 0, 0);
    chk("reset_beats_store", m_data_rdata, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
